// File: rtl/addsub_pkg.sv
// Shared constants for the add/subtract accumulator: FSM state encoding and op encoding.
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_unit.sv
// Combinational add/subtract datapath: a + (b ^ {N{sub}}) + sub with unsigned
// carry-out and two's-complement overflow. Holds no state.
module addsub_unit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N-1:0] b_x_s;
    logic [N:0]   full_s;

    // Condition the second operand, add with sub as carry-in, derive flags
    always_comb begin
        b_x_s  = b ^ {N{sub}};
        full_s = {1'b0, a} + {1'b0, b_x_s} + {{N{1'b0}}, sub};
        sum    = full_s[N-1:0];
        cout   = full_s[N];
        // Overflow: both addends share a sign that the result does not
        ovf    = (a[N-1] == b_x_s[N-1]) && (full_s[N-1] != a[N-1]);
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Burst add/subtract accumulator: start loads a burst length, operands are
// accumulated through a valid/ready handshake, result is offered with res_valid.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  operand,
    input  logic          op,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  acc,
    output logic          c_flag,
    output logic          v_flag
);

    state_t        state_r;
    state_t        state_n_s;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  acc_n_s;
    logic          c_r;
    logic          c_n_s;
    logic          v_r;
    logic          v_n_s;
    logic [LW-1:0] count_r;
    logic [LW-1:0] count_n_s;
    logic          in_ready_r;
    logic          res_valid_r;

    logic          sub_s;
    logic          transfer_s;
    logic [N-1:0]  sum_s;
    logic          cout_s;
    logic          ovf_s;

    assign sub_s      = (op == OP_SUB);
    assign transfer_s = in_valid && in_ready_r;

    addsub_unit #(.N(N)) u_addsub_unit (
        .a    (acc_r),
        .b    (operand),
        .sub  (sub_s),
        .sum  (sum_s),
        .cout (cout_s),
        .ovf  (ovf_s)
    );

    // Next-state and datapath update selection
    always_comb begin
        state_n_s = state_r;
        acc_n_s   = acc_r;
        c_n_s     = c_r;
        v_n_s     = v_r;
        count_n_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_n_s   = {N{1'b0}};
                    c_n_s     = 1'b0;
                    v_n_s     = 1'b0;
                    count_n_s = len;
                    state_n_s = (len == {LW{1'b0}}) ? ST_DONE : ST_ACC;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (transfer_s) begin
                    acc_n_s   = sum_s;
                    c_n_s     = c_r | (cout_s ^ sub_s);
                    v_n_s     = v_r | ovf_s;
                    count_n_s = count_r - LW'(1);
                    state_n_s = (count_r == LW'(1)) ? ST_DONE : ST_ACC;
                end else begin
                    state_n_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; handshakes decode the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {N{1'b0}};
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            count_r     <= {LW{1'b0}};
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            acc_r       <= acc_n_s;
            c_r         <= c_n_s;
            v_r         <= v_n_s;
            count_r     <= count_n_s;
            in_ready_r  <= (state_n_s == ST_ACC);
            res_valid_r <= (state_n_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign acc       = acc_r;
    assign c_flag    = c_r;
    assign v_flag    = v_r;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench for addsub_accumulator: bursts push expected results, a
// negedge monitor compares them whenever res_valid is presented.
module tb_addsub_accumulator;

    localparam int N  = 4;
    localparam int LW = 4;

    typedef struct packed {
        logic [N-1:0] acc;
        logic         c;
        logic         v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  operand = '0;
    logic          op = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [N-1:0]  acc;
    logic          c_flag;
    logic          v_flag;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    addsub_accumulator #(.N(N), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .op        (op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .acc       (acc),
        .c_flag    (c_flag),
        .v_flag    (v_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle a result is presented, compare it with the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_acc=%0d required=no_result", acc);
                end else begin
                    check("sb_acc", int'(acc), int'(exp_q[0].acc));
                    check("sb_c_flag", int'(c_flag), int'(exp_q[0].c));
                    check("sb_v_flag", int'(v_flag), int'(exp_q[0].v));
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_burst(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_ready", int'(in_ready), (l != 0) ? 1 : 0);
        check("start_res_valid", int'(res_valid), (l == 0) ? 1 : 0);
    endtask

    task automatic send(input logic [N-1:0] val, input logic o);
        int n = 0;
        in_valid = 1'b1;
        operand  = val;
        op       = o;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("take_res_valid", int'(res_valid), 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("idle_res_valid", int'(res_valid), 0);
        check("idle_in_ready", int'(in_ready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted between edges must clear outputs at once
        #2 rst_n = 1'b0;
        #1;
        check("rst_acc", int'(acc), 0);
        check("rst_c_flag", int'(c_flag), 0);
        check("rst_v_flag", int'(v_flag), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 5 + 3 - 2 = 6, signed overflow on 5+3
        exp_q.push_back('{acc: 4'd6, c: 1'b0, v: 1'b1});
        start_burst(4'd3);
        send(4'd5, 1'b0);
        send(4'd3, 1'b0);
        check("s1_not_done_early", int'(res_valid), 0);
        send(4'd2, 1'b1);
        check("s1_latency", int'(res_valid), 1);
        take_result();

        // 15 + 1 wraps to 0 with carry
        exp_q.push_back('{acc: 4'd0, c: 1'b1, v: 1'b0});
        start_burst(4'd2);
        send(4'd15, 1'b0);
        send(4'd1, 1'b0);
        check("s2_latency", int'(res_valid), 1);
        take_result();

        // 0 - 1 = 15 with borrow
        exp_q.push_back('{acc: 4'd15, c: 1'b1, v: 1'b0});
        start_burst(4'd1);
        send(4'd1, 1'b1);
        check("s3_latency", int'(res_valid), 1);
        take_result();

        // Zero-length burst, result held while res_ready stays low
        exp_q.push_back('{acc: 4'd0, c: 1'b0, v: 1'b0});
        start_burst(4'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("s4_hold_valid", int'(res_valid), 1);
        end
        take_result();

        // Gapped in_valid and a stray start while accumulating: 3 + 4 = 7
        exp_q.push_back('{acc: 4'd7, c: 1'b0, v: 1'b0});
        start_burst(4'd2);
        in_valid = 1'b1; operand = 4'd3; op = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; operand = 4'd9;
        check("s5_gap1_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        start = 1'b1; len = 4'd5;
        check("s5_gap2_ready", int'(in_ready), 1);
        check("s5_gap2_valid", int'(res_valid), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("s5_after_start_ready", int'(in_ready), 1);
        in_valid = 1'b1; operand = 4'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("s5_latency", int'(res_valid), 1);
        take_result();

        // Reset mid-burst discards the partial result
        start_burst(4'd3);
        send(4'd2, 1'b0);
        check("s6_pre_reset_acc", int'(acc), 2);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_acc", int'(acc), 0);
        check("s6_rst_in_ready", int'(in_ready), 0);
        check("s6_rst_res_valid", int'(res_valid), 0);
        check("s6_rst_flags", int'({c_flag, v_flag}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s6_idle_ready", int'(in_ready), 0);
        exp_q.push_back('{acc: 4'd7, c: 1'b0, v: 1'b0});
        start_burst(4'd1);
        send(4'd7, 1'b0);
        check("s6_latency", int'(res_valid), 1);
        take_result();

        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/accumulator width in bits.
REQ-002 SHALL have parameter LW, default 4, meaning burst-length field width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a begin-burst request, sampled only in IDLE.
REQ-006 SHALL have port len, input, LW, meaning the number of operands in the burst, sampled with start.
REQ-007 SHALL have port in_valid, input, 1, meaning the operand is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts an operand.
REQ-009 SHALL have port operand, input, N, meaning the operand value.
REQ-010 SHALL have port op, input, 1, meaning 0 = add and 1 = subtract, qualified by in_valid.
REQ-011 SHALL have port res_valid, output, 1, meaning the result is available.
REQ-012 SHALL have port res_ready, input, 1, meaning the consumer takes the result.
REQ-013 SHALL have port acc, output, N, meaning the accumulated result.
REQ-014 SHALL have port c_flag, output, 1, meaning a sticky unsigned carry (add) or borrow (sub) occurred.
REQ-015 SHALL have port v_flag, output, 1, meaning a sticky two's-complement overflow occurred.

Function
REQ-016 SHALL implement FSM states IDLE, ACC and DONE.
REQ-017 SHALL transition IDLE->ACC on start=1 with len!=0, clearing acc, c_flag and v_flag and loading the remaining-count register with len.
REQ-018 SHALL transition IDLE->DONE on start=1 with len=0, with acc=0 and both flags 0.
REQ-019 SHALL drive in_ready=1 only in ACC, and SHALL count an operand as transferred on any edge where in_valid and in_ready are both 1.
REQ-020 SHALL, on each transfer, compute acc_next = acc + (operand XOR {N{op}}) + op, truncated to N bits, and register it on that same edge.
REQ-021 SHALL detect unsigned event as cout XOR op (carry on add, borrow on sub) and OR it into c_flag.
REQ-022 SHALL detect signed overflow as operands of equal sign (acc and the inverted-or-not operand) producing a result of different sign, and OR it into v_flag.
REQ-023 SHALL decrement the remaining count per transfer, and on the transfer that brings it to 0 SHALL transition ACC->DONE on that same edge; res_valid is therefore high in the cycle after the last transfer.
REQ-024 SHALL hold in ACC indefinitely with in_valid=0, with no state change.
REQ-025 SHALL drive res_valid=1 only in DONE, and SHALL hold acc, c_flag and v_flag stable while res_ready=0.
REQ-026 SHALL transition DONE->IDLE on the edge where res_ready=1, and SHALL leave acc and the flags unchanged.
REQ-027 SHALL ignore start outside IDLE, and SHALL ignore res_ready outside DONE.
REQ-028 SHALL make acc, c_flag and v_flag visible at all times; they are meaningful only when res_valid=1.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, acc=0, c_flag=0, v_flag=0, count=0, in_ready=0 and res_valid=0, regardless of clk.
REQ-030 SHALL, on reset asserted mid-burst, discard the partial result, and the first start after release SHALL begin a fresh burst.

Structure
REQ-031 SHALL define the FSM state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the op encoding constants in a shared package/include, addsub_pkg.
REQ-032 SHALL place the XOR-conditioned ripple add/subtract datapath (inputs a, b, sub; outputs sum, cout, ovf) in one combinational sub-module, addsub_unit, instantiated once.
REQ-033 SHALL contain all registers in addsub_accumulator and none in addsub_unit.

Verification (N=4)
REQ-034 SHALL cover: start len=3; ops +5, +3, -2 -> res_valid 1 cycle after the 3rd transfer; acc=6, c_flag=0, v_flag=1 (5+3 overflows signed).
REQ-035 SHALL cover: len=2; ops +15, +1 -> acc=0, c_flag=1, v_flag=0.
REQ-036 SHALL cover: len=1; op -1 from 0 -> acc=15, c_flag=1 (borrow), v_flag=0.
REQ-037 SHALL cover: len=0 -> DONE on the next edge with acc=0 and flags 0; then res_ready=0 for 3 cycles -> res_valid, acc and flags held; res_ready=1 -> IDLE next edge.
REQ-038 SHALL cover: in_valid toggled 1,0,0,1 during len=2 -> exactly 2 transfers, and acc equals the sum of only the transferred operands; start pulsed in ACC has no effect.
REQ-039 SHALL cover: rst_n low mid-cycle after 1 of 3 transfers -> outputs 0 and IDLE immediately, without waiting for a clk edge; after release, a new len=1 burst of +7 gives acc=7.
